// File: rtl/tx_8b10b_kchar_if.sv
// Byte-side and serial-side signals of the 8b/10b K-capable transmitter.
// The master drives writes and bit strobes; the slave (transmitter) drives status and tx.
interface tx_8b10b_kchar_if;
    logic       en;
    logic [7:0] dataIn;
    logic       isK;
    logic       writeStrobe;
    logic       dataPresent;
    logic       halfFull;
    logic       full;
    logic       kError;
    logic       tx;

    modport master (
        output en, dataIn, isK, writeStrobe,
        input  dataPresent, halfFull, full, kError, tx
    );

    modport slave (
        input  en, dataIn, isK, writeStrobe,
        output dataPresent, halfFull, full, kError, tx
    );
endinterface

// File: rtl/tx_8b10b_kchar.sv
// 8b/10b serial transmitter with K-character support and a first-word-fall-through TX FIFO.
// Symbols leave MSB (bit a) first, one bit per en strobe; fill words go out whenever the FIFO is idle.
module tx_8b10b_kchar #(
    parameter logic [9:0] FILL_WORD_RD0  = 10'b0011111010,
    parameter logic [9:0] FILL_WORD_RD1  = 10'b1100000101,
    parameter logic       FILL_WORD_FLIP = 1'b1,
    parameter int         LOG2_DEPTH     = 4
) (
    input logic             clk,
    input logic             rst,
    tx_8b10b_kchar_if.slave bus
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] C_DEPTH = {1'b1, {LOG2_DEPTH{1'b0}}};
    localparam logic [LOG2_DEPTH:0] C_HALF  = {2'b01, {(LOG2_DEPTH-1){1'b0}}};

    logic [8:0]            r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_count;
    logic                  r_data_present;
    logic                  r_half_full;
    logic                  r_full;
    logic                  r_k_error;
    logic [9:0]            r_shift;
    logic [3:0]            r_bit_cnt;
    logic                  r_rd;

    logic                  w_load;
    logic                  w_pop;
    logic                  w_push;
    logic [LOG2_DEPTH:0]   w_count_next;
    logic [8:0]            w_head;
    logic [4:0]            w_x;
    logic [2:0]            w_y;
    logic                  w_is_k;
    logic                  w_k_valid;
    logic [5:0]            w_6b_neg;
    logic                  w_6b_flip;
    logic [5:0]            w_6b;
    logic                  w_rd_mid;
    logic                  w_alt7;
    logic [3:0]            w_4b_neg;
    logic                  w_4b_flip;
    logic [3:0]            w_4b;
    logic                  w_rd_end;
    logic [9:0]            w_sym;

    // 5b/6b codes as seen at RD-; the RD+ code is the complement for unbalanced entries and D.7
    function automatic logic [5:0] f_enc6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] f_d4_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] f_k4_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b0110;
            3'd2:    c = 4'b1010;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b0101;
            3'd6:    c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] f_ones6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    function automatic logic [2:0] f_ones4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    assign w_load = bus.en && (r_bit_cnt == 4'd9);
    assign w_pop  = w_load && r_data_present;
    assign w_push = bus.writeStrobe && (!r_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.isK, bus.dataIn};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_data_present <= 1'b0;
            r_half_full    <= 1'b0;
            r_full         <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count        <= w_count_next;
            r_data_present <= (w_count_next != '0);
            r_half_full    <= (w_count_next >= C_HALF);
            r_full         <= (w_count_next == C_DEPTH);
        end
    end

    // Encoder works sub-block-wise: the 4b choice depends on the RD left behind by the 6b code
    always_comb begin
        w_head    = r_mem[r_rd_ptr];
        w_x       = w_head[4:0];
        w_y       = w_head[7:5];
        w_is_k    = w_head[8];
        w_k_valid = (w_x == 5'd28) ||
                    ((w_y == 3'd7) && ((w_x == 5'd23) || (w_x == 5'd27) ||
                                       (w_x == 5'd29) || (w_x == 5'd30)));

        w_6b_neg  = (w_is_k && (w_x == 5'd28)) ? 6'b001111 : f_enc6_neg(w_x);
        w_6b_flip = (f_ones6(w_6b_neg) != 3'd3) || (w_x == 5'd7);
        w_6b      = (r_rd && w_6b_flip) ? ~w_6b_neg : w_6b_neg;
        w_rd_mid  = r_rd ^ (f_ones6(w_6b) != 3'd3);

        // D.x.A7 avoids a run of five equal bits across the sub-block boundary
        w_alt7 = (w_y == 3'd7) &&
                 ((!w_rd_mid && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                  ( w_rd_mid && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));

        if (w_is_k) begin
            w_4b_neg  = f_k4_neg(w_y);
            w_4b_flip = 1'b1;
        end else begin
            w_4b_neg  = w_alt7 ? 4'b0111 : f_d4_neg(w_y);
            w_4b_flip = (w_y == 3'd0) || (w_y == 3'd3) || (w_y == 3'd4) || (w_y == 3'd7);
        end
        w_4b     = (w_rd_mid && w_4b_flip) ? ~w_4b_neg : w_4b_neg;
        w_rd_end = w_rd_mid ^ (f_ones4(w_4b) != 3'd2);
        w_sym    = {w_6b, w_4b};
    end

    // Invalid K entries are consumed but replaced on the line by the fill word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_bit_cnt <= 4'd9;
            r_rd      <= 1'b0;
            r_k_error <= 1'b0;
        end else begin
            r_k_error <= 1'b0;
            if (w_load) begin
                r_bit_cnt <= 4'd0;
                if (w_pop && (!w_is_k || w_k_valid)) begin
                    r_shift <= w_sym;
                    r_rd    <= w_rd_end;
                end else begin
                    r_shift   <= r_rd ? FILL_WORD_RD1 : FILL_WORD_RD0;
                    r_rd      <= r_rd ^ FILL_WORD_FLIP;
                    r_k_error <= w_pop;
                end
            end else if (bus.en) begin
                r_shift   <= {r_shift[8:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign bus.tx          = r_shift[9];
    assign bus.dataPresent = r_data_present;
    assign bus.halfFull    = r_half_full;
    assign bus.full        = r_full;
    assign bus.kError      = r_k_error;

endmodule

// File: tb/tb_tx_8b10b_kchar.sv
// Self-checking bench for tx_8b10b_kchar: directed link scenarios plus randomized traffic
// compared against a table-driven 8b/10b reference model with a queue standing in for the FIFO.
module tb_tx_8b10b_kchar;

    localparam int         GAP       = 7;
    localparam int         DEPTH     = 16;
    localparam logic [9:0] FILL_RD0  = 10'b0011111010;
    localparam logic [9:0] FILL_RD1  = 10'b1100000101;
    localparam bit         FILL_FLIP = 1'b1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [8:0] model_q[$];
    bit         model_rd;

    tx_8b10b_kchar_if bus ();

    tx_8b10b_kchar dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Standard code tables, {RD- column, RD+ column}
    function automatic logic [11:0] tab6(input int x);
        case (x)
            0:  return {6'b100111, 6'b011000};
            1:  return {6'b011101, 6'b100010};
            2:  return {6'b101101, 6'b010010};
            3:  return {6'b110001, 6'b110001};
            4:  return {6'b110101, 6'b001010};
            5:  return {6'b101001, 6'b101001};
            6:  return {6'b011001, 6'b011001};
            7:  return {6'b111000, 6'b000111};
            8:  return {6'b111001, 6'b000110};
            9:  return {6'b100101, 6'b100101};
            10: return {6'b010101, 6'b010101};
            11: return {6'b110100, 6'b110100};
            12: return {6'b001101, 6'b001101};
            13: return {6'b101100, 6'b101100};
            14: return {6'b011100, 6'b011100};
            15: return {6'b010111, 6'b101000};
            16: return {6'b011011, 6'b100100};
            17: return {6'b100011, 6'b100011};
            18: return {6'b010011, 6'b010011};
            19: return {6'b110010, 6'b110010};
            20: return {6'b001011, 6'b001011};
            21: return {6'b101010, 6'b101010};
            22: return {6'b011010, 6'b011010};
            23: return {6'b111010, 6'b000101};
            24: return {6'b110011, 6'b001100};
            25: return {6'b100110, 6'b100110};
            26: return {6'b010110, 6'b010110};
            27: return {6'b110110, 6'b001001};
            28: return {6'b001110, 6'b001110};
            29: return {6'b101110, 6'b010001};
            30: return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    function automatic logic [7:0] tabd4(input int y);
        case (y)
            0: return {4'b1011, 4'b0100};
            1: return {4'b1001, 4'b1001};
            2: return {4'b0101, 4'b0101};
            3: return {4'b1100, 4'b0011};
            4: return {4'b1101, 4'b0010};
            5: return {4'b1010, 4'b1010};
            6: return {4'b0110, 4'b0110};
            default: return {4'b1110, 4'b0001};
        endcase
    endfunction

    function automatic logic [7:0] tabk4(input int y);
        case (y)
            0: return {4'b1011, 4'b0100};
            1: return {4'b0110, 4'b1001};
            2: return {4'b1010, 4'b0101};
            3: return {4'b1100, 4'b0011};
            4: return {4'b1101, 4'b0010};
            5: return {4'b0101, 4'b1010};
            6: return {4'b1001, 4'b0110};
            default: return {4'b0111, 4'b1000};
        endcase
    endfunction

    function automatic logic [8:0] rand_entry();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) begin
            case ($urandom_range(0, 11))
                0: return 9'h11C;  1: return 9'h13C;  2: return 9'h15C;  3: return 9'h17C;
                4: return 9'h19C;  5: return 9'h1BC;  6: return 9'h1DC;  7: return 9'h1FC;
                8: return 9'h1F7;  9: return 9'h1FB;  10: return 9'h1FD; default: return 9'h1FE;
            endcase
        end else if (r == 1) begin
            return {1'b1, 8'($urandom_range(0, 255))};
        end
        return {1'b0, 8'($urandom_range(0, 255))};
    endfunction

    task automatic model_push(input logic [8:0] e);
        if (model_q.size() < DEPTH) model_q.push_back(e);
    endtask

    // Next symbol on the line: pop the queue head if any, else a fill word
    task automatic model_load(output logic [9:0] sym, output int kerr);
        logic [8:0]  e;
        int          x, y;
        logic [11:0] t6;
        logic [7:0]  t4;
        logic [5:0]  s6;
        logic [3:0]  s4;
        bit          mid, valid;
        kerr  = 0;
        valid = 1'b0;
        x     = 0;
        y     = 0;
        if (model_q.size() != 0) begin
            e     = model_q.pop_front();
            x     = int'(e[4:0]);
            y     = int'(e[7:5]);
            valid = !e[8] || x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
            kerr  = valid ? 0 : 1;
        end else begin
            e = '0;
        end
        if (!valid) begin
            sym      = model_rd ? FILL_RD1 : FILL_RD0;
            model_rd = model_rd ^ FILL_FLIP;
        end else begin
            t6  = (e[8] && x == 28) ? {6'b001111, 6'b110000} : tab6(x);
            s6  = model_rd ? t6[5:0] : t6[11:6];
            mid = model_rd ^ ($countones(s6) != 3);
            if (e[8])
                t4 = tabk4(y);
            else if (y == 7 && ((!mid && (x == 17 || x == 18 || x == 20)) ||
                                ( mid && (x == 11 || x == 13 || x == 14))))
                t4 = {4'b0111, 4'b1000};
            else
                t4 = tabd4(y);
            s4  = mid ? t4[3:0] : t4[7:4];
            sym = {s6, s4};
            if ($countones(sym) != 5) model_rd = ~model_rd;
        end
    endtask

    task automatic push_entry(input logic [8:0] e);
        bus.writeStrobe        = 1'b1;
        {bus.isK, bus.dataIn}  = e;
        @(posedge clk); #1;
        bus.writeStrobe        = 1'b0;
        model_push(e);
    endtask

    // Ten en strobes, GAP idle clocks after each; optional write in the load cycle
    task automatic get_symbol(input bit wr, input logic [8:0] wr_e, output logic [9:0] sym,
                              output int k_cnt, output logic dp_end);
        sym   = '0;
        k_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            bus.en = 1'b1;
            if (i == 0 && wr) begin
                bus.writeStrobe       = 1'b1;
                {bus.isK, bus.dataIn} = wr_e;
            end
            @(posedge clk); #1;
            bus.en          = 1'b0;
            bus.writeStrobe = 1'b0;
            sym = {sym[8:0], bus.tx};
            if (bus.kError === 1'b1) k_cnt++;
            for (int g = 0; g < GAP; g++) begin
                @(posedge clk); #1;
                if (bus.kError === 1'b1) k_cnt++;
            end
        end
        dp_end = bus.dataPresent;
    endtask

    task automatic step(input bit wr, input logic [8:0] wr_e, output logic [9:0] got,
                        output logic [9:0] exp, output int k_got, output int k_exp,
                        output logic dp_got, output logic dp_exp);
        model_load(exp, k_exp);
        if (wr) model_push(wr_e);
        get_symbol(wr, wr_e, got, k_got, dp_got);
        dp_exp = (model_q.size() != 0);
    endtask

    task automatic align_rd_neg();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        if (model_rd) begin
            step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL align_fill: got %b expected %b", got, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.tx, bus.dataPresent, bus.halfFull, bus.full, bus.kError} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tx/dp/hf/full/kerr=%b expected 00000",
                     {bus.tx, bus.dataPresent, bus.halfFull, bus.full, bus.kError});
        end
        rst = 1'b1;
        model_q.delete();
        model_rd = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if ({bus.tx, bus.dataPresent, bus.halfFull, bus.full} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 0000",
                     {bus.tx, bus.dataPresent, bus.halfFull, bus.full});
        end
    endtask

    task automatic test_fill();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== ((i % 2 == 0) ? FILL_RD0 : FILL_RD1)) begin
                n_fail++;
                $display("FAIL fill[%0d]: got %b expected %b", i, got,
                         (i % 2 == 0) ? FILL_RD0 : FILL_RD1);
            end
            n_checks++;
            if (dpg !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_dp[%0d]: got %b expected 0", i, dpg);
            end
        end
    endtask

    task automatic test_d00();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        align_rd_neg();
        push_entry(9'h000);
        push_entry(9'h000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== ((i < 2) ? 10'b1001110100 : FILL_RD0)) begin
                n_fail++;
                $display("FAIL d00[%0d]: got %b expected %b", i, got,
                         (i < 2) ? 10'b1001110100 : FILL_RD0);
            end
        end
    endtask

    task automatic test_d21_k285();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        align_rd_neg();
        push_entry(9'h0B5);
        step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== 10'b1010101010) begin
            n_fail++;
            $display("FAIL d21_5: got %b expected 1010101010", got);
        end
        push_entry(9'h1BC);
        step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== 10'b0011111010 || kg !== 0) begin
            n_fail++;
            $display("FAIL k28_5: got %b kerr=%0d expected 0011111010 kerr=0", got, kg);
        end
        step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== FILL_RD1) begin
            n_fail++;
            $display("FAIL k28_5_rd: got %b expected %b", got, FILL_RD1);
        end
    endtask

    task automatic test_invalid_k();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        align_rd_neg();
        push_entry(9'h100);
        step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== FILL_RD0) begin
            n_fail++;
            $display("FAIL bad_k_sym: got %b expected %b", got, FILL_RD0);
        end
        n_checks++;
        if (kg !== 1) begin
            n_fail++;
            $display("FAIL bad_k_pulse: got %0d cycles expected 1", kg);
        end
        step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== FILL_RD1 || kg !== 0) begin
            n_fail++;
            $display("FAIL bad_k_rd: got %b kerr=%0d expected %b kerr=0", got, kg, FILL_RD1);
        end
    endtask

    task automatic test_alt7();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        logic [8:0] list [7];
        list = '{9'h0F1, 9'h0F2, 9'h0F4, 9'h0EB, 9'h0ED, 9'h0EE, 9'h0E7};
        foreach (list[i]) begin
            push_entry(list[i]);
            push_entry(list[i]);
            for (int j = 0; j < 2; j++) begin
                step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL alt7[%h.%0d]: got %b expected %b", list[i], j, got, exp);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        for (int n = 1; n <= DEPTH + 1; n++) begin
            push_entry(rand_entry());
            n_checks++;
            if (bus.halfFull !== (model_q.size() >= DEPTH / 2) || bus.full !== (model_q.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL flags_write[%0d]: got hf=%b full=%b expected hf=%b full=%b", n,
                         bus.halfFull, bus.full, model_q.size() >= DEPTH / 2, model_q.size() == DEPTH);
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== exp || kg !== ke || dpg !== dpe) begin
                n_fail++;
                $display("FAIL drain[%0d]: got %b k=%0d dp=%b expected %b k=%0d dp=%b",
                         i, got, kg, dpg, exp, ke, dpe);
            end
        end
    endtask

    task automatic test_write_at_load();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        step(1'b1, 9'h03C, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== exp || dpg !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_wr_load: got %b dp=%b expected %b dp=1", got, dpg, exp);
        end
        step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL empty_wr_next: got %b expected %b", got, exp);
        end
        for (int n = 0; n < DEPTH; n++) push_entry(rand_entry());
        step(1'b1, 9'h0A5, got, exp, kg, ke, dpg, dpe);
        n_checks++;
        if (got !== exp || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wr_load: got %b full=%b expected %b full=1", got, bus.full, exp);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== exp || kg !== ke || dpg !== dpe) begin
                n_fail++;
                $display("FAIL full_wr_drain[%0d]: got %b k=%0d dp=%b expected %b k=%0d dp=%b",
                         i, got, kg, dpg, exp, ke, dpe);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        int         kg, ke, n;
        logic       dpg, dpe;
        bit         wr;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) push_entry(rand_entry());
            wr = ($urandom_range(0, 3) == 0);
            step(wr, rand_entry(), got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== exp || kg !== ke || dpg !== dpe) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b k=%0d dp=%b expected %b k=%0d dp=%b",
                         i, got, kg, dpg, exp, ke, dpe);
            end
        end
        for (int d = 0; d < DEPTH + 2 && model_q.size() != 0; d++) begin
            step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== exp || kg !== ke) begin
                n_fail++;
                $display("FAIL random_drain[%0d]: got %b k=%0d expected %b k=%0d", d, got, kg, exp, ke);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got, exp;
        int         kg, ke;
        logic       dpg, dpe;
        push_entry(9'h0B5);
        push_entry(9'h000);
        push_entry(9'h1BC);
        push_entry(9'h07E);
        for (int i = 0; i < 5; i++) begin
            bus.en = 1'b1;
            @(posedge clk); #1;
            bus.en = 1'b0;
            if (i < 4) repeat (GAP) begin @(posedge clk); #1; end
        end
        n_checks++;
        if (bus.tx !== 1'b1 || bus.dataPresent !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_bit4: got tx=%b dp=%b expected tx=1 dp=1", bus.tx, bus.dataPresent);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.tx, bus.dataPresent, bus.halfFull, bus.full, bus.kError} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %b expected 00000",
                     {bus.tx, bus.dataPresent, bus.halfFull, bus.full, bus.kError});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        model_q.delete();
        model_rd = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 9'h0, got, exp, kg, ke, dpg, dpe);
            n_checks++;
            if (got !== ((i == 0) ? FILL_RD0 : FILL_RD1) || dpg !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset[%0d]: got %b dp=%b expected %b dp=0", i, got, dpg,
                         (i == 0) ? FILL_RD0 : FILL_RD1);
            end
        end
    endtask

    initial begin
        bus.en          = 1'b0;
        bus.dataIn      = 8'h00;
        bus.isK         = 1'b0;
        bus.writeStrobe = 1'b0;
        model_rd        = 1'b0;
        test_reset();
        test_fill();
        test_d00();
        test_d21_k285();
        test_invalid_k();
        test_alt7();
        test_full();
        test_write_at_load();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_8b10b_kchar.md
Name: tx_8b10b_kchar

Overview:
- Serial 8b10b transmitter with a control-character (K) path and a transmit FIFO.
- Entries are {isK, data}. Each entry is encoded as a data symbol (Dx.y) or a control symbol (Kx.y) with running disparity, then shifted out one bit per `en` strobe.
- When the FIFO is empty, fill words are sent.
- It is the far-end source for the Rx8b10b receiver, and adds K-code transmission for link framing.

Parameters:
- FILL_WORD_RD0, 10'b0011111010, fill symbol sent when FIFO empty and RD=-1
- FILL_WORD_RD1, 10'b1100000101, fill symbol sent when FIFO empty and RD=+1
- FILL_WORD_FLIP, 1'b1, fill word inverts RD when 1
- LOG2_DEPTH, 4, log2 of FIFO depth; integer >= 2

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  reset, asynchronous, active-low
- en  in  1  bit strobe; one pulse per transmitted bit
- dataIn  in  8  byte to send; for K entries, the K code byte
- isK  in  1  qualifies dataIn as a control character
- writeStrobe  in  1  push {isK, dataIn} into FIFO
- dataPresent  out  1  FIFO non-empty
- halfFull  out  1  FIFO count >= 2^(LOG2_DEPTH-1)
- full  out  1  FIFO count == 2^LOG2_DEPTH
- kError  out  1  one-cycle pulse: invalid K code popped
- tx  out  1  serial output, registered

Behaviour:
Reset (rst=0, asynchronous):
- FIFO empty; dataPresent=0, halfFull=0, full=0.
- kError=0, tx=0, shift register=0.
- bitCnt=9, so the first `en` loads a symbol.
- RD=-1.

FIFO:
- 9 bits wide, depth 2^LOG2_DEPTH, first-word fall-through head.
- writeStrobe while full and no pop in the same cycle: write dropped, no state change.
- Write and pop in the same cycle while full: both happen; count unchanged.
- Write into an empty FIFO in the same cycle as a load: the load sends fill; the written entry goes out in the next symbol.
- Status flags are registered from count and update the cycle after a push or pop.

Serializer:
- Symbol bit order: bit 9 = a, bit 0 = j (abcdei fghj). Transmitted MSB first.
- tx = shift[9].
- On `en` with bitCnt==9, load a new symbol and set bitCnt=0:
  - FIFO non-empty: pop the head and load the encoded symbol.
  - FIFO empty: load FILL_WORD_RD0 or FILL_WORD_RD1 according to RD.
- On `en` otherwise: shift left 1, bitCnt+1.
- No `en`: all serializer state holds.
- tx changes only in the clk after an `en`. Each symbol occupies exactly 10 `en` periods; no gaps.

Encoder:
- Data entries: standard 5b/6b then 3b/4b tables with RD selection, including the D.x.A7 alternate encoding (x=17,18,20 at RD-; x=11,13,14 at RD+).
- Valid K entries: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7, encoded with standard K tables.
- Invalid K code: send the fill word for the current RD, pulse kError for one clk in the load cycle, and update RD as for a fill word.

Running disparity:
- After each load, RD inverts if the symbol disparity is non-zero.
- Fill words invert RD only when FILL_WORD_FLIP=1.
- The RD update is computed sub-block-wise (after 6b, then after 4b) per the standard.

Reset mid-symbol:
- The current symbol is aborted and tx=0 immediately.
- Queued FIFO contents are discarded.

Test Plan:
- Reset, FIFO empty, `en` every 8 clk → tx shows 0011111010, then 1100000101, alternating (FILL_WORD_FLIP=1). dataPresent=0 throughout.
- Push D0.0 (isK=0, 0x00) twice at RD-:
  - both symbols = 1001110100; RD stays -1;
  - the following fill = 0011111010.
- Push D21.5 (0xB5) at RD- → 1010101010; RD unchanged. Then push K28.5 (isK=1, 0xBC) → 0011111010; RD becomes +1.
- Push isK=1, 0x00 (invalid K) at RD- → kError pulses exactly one clk at the load; tx = 0011111010; RD becomes +1.
- With `en` held low, write 16 entries:
  - full=1 after the 16th write, halfFull=1 after the 8th;
  - the 17th write is ignored;
  - resume `en` → exactly 16 encoded symbols, then fill; dataPresent falls after the 16th pop.
- Assert rst=0 at bit 4 of a data symbol → tx=0 and flags clear without a clk edge. After release, the first `en` loads fill 0011111010.
